mc_bus_regs: RTL and testbench

- Register controller between the MCU parallel memory-controller bus (ce/we/oe strobes, 6-bit address, 16-bit data) and the FPGA peripherals.
- Synchronises the asynchronous MCU strobes into the FPGA clock domain and decodes reads and writes.
- Holds the configuration that drives the five Bus Pirate IO buffers (oe, dir, od, dout) and the AUX PWM on/off periods.
- Returns readback data plus an output-enable for the mc_data tristate pads.

---
 rtl/mc_bus_regs.sv | 240 ++++++++++++++++++++++++
 tb/tb_mc_bus_regs.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mc_bus_regs.sv
// MCU parallel-bus register file: syncs async strobes, decodes R/W, holds IO buffer and PWM config.
// Latency: read data/oe valid SYNC_STAGES+1 clocks after mc_oe falls; writes land 1 clock after synced WE rises.
// Backpressure: none; the MCU must hold address/data SYNC_STAGES+2 clocks past the WE rising edge.
module mc_bus_regs #(
    parameter int                 MC_DATA_WIDTH = 16,
    parameter int                 MC_ADD_WIDTH  = 6,
    parameter int                 SYNC_STAGES   = 2,
    parameter logic [15:0]        PWM_ON_RST    = 16'h0002,
    parameter logic [15:0]        PWM_OFF_RST   = 16'h0081
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mc_ce,
    input  logic                     mc_we,
    input  logic                     mc_oe,
    input  logic [MC_ADD_WIDTH-1:0]  mc_add,
    input  logic [MC_DATA_WIDTH-1:0] mc_din,
    output logic [MC_DATA_WIDTH-1:0] mc_dout,
    output logic                     mc_dout_en,
    output logic [4:0]               buf_oe,
    output logic [4:0]               buf_dir,
    output logic [4:0]               buf_od,
    output logic [4:0]               buf_dout,
    input  logic [4:0]               buf_din,
    output logic [15:0]              pwm_on,
    output logic [15:0]              pwm_off,
    output logic                     pwm_reset
);

    localparam logic [MC_ADD_WIDTH-1:0] A_ID      = MC_ADD_WIDTH'(8'h00);
    localparam logic [MC_ADD_WIDTH-1:0] A_CTRL    = MC_ADD_WIDTH'(8'h01);
    localparam logic [MC_ADD_WIDTH-1:0] A_PWM_ON  = MC_ADD_WIDTH'(8'h02);
    localparam logic [MC_ADD_WIDTH-1:0] A_PWM_OFF = MC_ADD_WIDTH'(8'h03);
    localparam logic [MC_ADD_WIDTH-1:0] A_BUF_OE  = MC_ADD_WIDTH'(8'h04);
    localparam logic [MC_ADD_WIDTH-1:0] A_BUF_DIR = MC_ADD_WIDTH'(8'h05);
    localparam logic [MC_ADD_WIDTH-1:0] A_BUF_OD  = MC_ADD_WIDTH'(8'h06);
    localparam logic [MC_ADD_WIDTH-1:0] A_BUF_DO  = MC_ADD_WIDTH'(8'h07);
    localparam logic [MC_ADD_WIDTH-1:0] A_BUF_DIN = MC_ADD_WIDTH'(8'h08);
    localparam logic [MC_ADD_WIDTH-1:0] A_SCRATCH = MC_ADD_WIDTH'(8'h09);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    // ---------------- input synchronisers ----------------
    logic [SYNC_STAGES-1:0]   ce_sync_q, ce_sync_d;
    logic [SYNC_STAGES-1:0]   we_sync_q, we_sync_d;
    logic [SYNC_STAGES-1:0]   oe_sync_q, oe_sync_d;
    logic [MC_ADD_WIDTH-1:0]  add_sync_q [SYNC_STAGES];
    logic [MC_ADD_WIDTH-1:0]  add_sync_d [SYNC_STAGES];
    logic [MC_DATA_WIDTH-1:0] din_sync_q [SYNC_STAGES];
    logic [MC_DATA_WIDTH-1:0] din_sync_d [SYNC_STAGES];
    logic [4:0]               bdin_sync_q [SYNC_STAGES];
    logic [4:0]               bdin_sync_d [SYNC_STAGES];

    logic                     ce_s, we_s, oe_s;
    logic [MC_ADD_WIDTH-1:0]  add_s;
    logic [MC_DATA_WIDTH-1:0] din_s;
    logic [4:0]               buf_din_s;

    always_comb begin
        ce_sync_d = {ce_sync_q[SYNC_STAGES-2:0], mc_ce};
        we_sync_d = {we_sync_q[SYNC_STAGES-2:0], mc_we};
        oe_sync_d = {oe_sync_q[SYNC_STAGES-2:0], mc_oe};
        add_sync_d[0]  = mc_add;
        din_sync_d[0]  = mc_din;
        bdin_sync_d[0] = buf_din;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            add_sync_d[i]  = add_sync_q[i-1];
            din_sync_d[i]  = din_sync_q[i-1];
            bdin_sync_d[i] = bdin_sync_q[i-1];
        end
    end

    assign ce_s      = ce_sync_q[SYNC_STAGES-1];
    assign we_s      = we_sync_q[SYNC_STAGES-1];
    assign oe_s      = oe_sync_q[SYNC_STAGES-1];
    assign add_s     = add_sync_q[SYNC_STAGES-1];
    assign din_s     = din_sync_q[SYNC_STAGES-1];
    assign buf_din_s = bdin_sync_q[SYNC_STAGES-1];

    // ---------------- state and registers ----------------
    state_t                   state_q, state_d;
    logic                     commit;
    logic                     apply;
    logic [15:0]              rd_val;

    logic [MC_DATA_WIDTH-1:0] mc_dout_q, mc_dout_d;
    logic                     mc_dout_en_q, mc_dout_en_d;
    logic [4:0]               buf_oe_q, buf_oe_d;
    logic [4:0]               buf_dir_q, buf_dir_d;
    logic [4:0]               buf_od_q, buf_od_d;
    logic [4:0]               buf_dout_q, buf_dout_d;
    logic [15:0]              pwm_on_q, pwm_on_d;
    logic [15:0]              pwm_off_q, pwm_off_d;
    logic [15:0]              pwm_on_sh_q, pwm_on_sh_d;
    logic [15:0]              pwm_off_sh_q, pwm_off_sh_d;
    logic                     enable_q, enable_d;
    logic [15:0]              scratch_q, scratch_d;
    logic                     apply_pulse_q, apply_pulse_d;

    // Write wins over read when both strobes are low; WE rising commits even if CE rises with it.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ce_s && !we_s)      state_d = WR;
                else if (!ce_s && !oe_s) state_d = RD;
            end
            WR: begin
                if (we_s) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else if (ce_s) begin
                    state_d = IDLE;
                end
            end
            RD: begin
                if (oe_s || ce_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_val = 16'h0000;
        case (add_s)
            A_ID:      rd_val = 16'hB9A1;
            A_CTRL:    rd_val = {15'd0, enable_q};
            A_PWM_ON:  rd_val = pwm_on_sh_q;
            A_PWM_OFF: rd_val = pwm_off_sh_q;
            A_BUF_OE:  rd_val = {11'd0, buf_oe_q};
            A_BUF_DIR: rd_val = {11'd0, buf_dir_q};
            A_BUF_OD:  rd_val = {11'd0, buf_od_q};
            A_BUF_DO:  rd_val = {11'd0, buf_dout_q};
            A_BUF_DIN: rd_val = {11'd0, buf_din_s};
            A_SCRATCH: rd_val = scratch_q;
            default:   rd_val = 16'h0000;
        endcase
    end

    always_comb begin
        buf_oe_d     = buf_oe_q;
        buf_dir_d    = buf_dir_q;
        buf_od_d     = buf_od_q;
        buf_dout_d   = buf_dout_q;
        pwm_on_sh_d  = pwm_on_sh_q;
        pwm_off_sh_d = pwm_off_sh_q;
        enable_d     = enable_q;
        scratch_d    = scratch_q;
        pwm_on_d     = pwm_on_q;
        pwm_off_d    = pwm_off_q;
        apply        = 1'b0;
        if (commit) begin
            case (add_s)
                A_CTRL: begin
                    enable_d = din_s[0];
                    apply    = din_s[1] || (din_s[0] && !enable_q);
                end
                A_PWM_ON:  pwm_on_sh_d  = din_s[15:0];
                A_PWM_OFF: pwm_off_sh_d = din_s[15:0];
                A_BUF_OE:  buf_oe_d     = din_s[4:0];
                A_BUF_DIR: buf_dir_d    = din_s[4:0];
                A_BUF_OD:  buf_od_d     = din_s[4:0];
                A_BUF_DO:  buf_dout_d   = din_s[4:0];
                A_SCRATCH: scratch_d    = din_s[15:0];
                default: ;
            endcase
        end
        if (apply) begin
            pwm_on_d  = pwm_on_sh_q;
            pwm_off_d = pwm_off_sh_q;
        end
        apply_pulse_d = apply;
        // Load read data on the RD entry edge so data and enable appear together.
        mc_dout_en_d  = (state_d == RD);
        mc_dout_d     = (state_d == RD) ? MC_DATA_WIDTH'(rd_val) : mc_dout_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ce_sync_q     <= '1;
            we_sync_q     <= '1;
            oe_sync_q     <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                add_sync_q[i]  <= '0;
                din_sync_q[i]  <= '0;
                bdin_sync_q[i] <= '0;
            end
            state_q       <= IDLE;
            mc_dout_q     <= '0;
            mc_dout_en_q  <= 1'b0;
            buf_oe_q      <= '0;
            buf_dir_q     <= '0;
            buf_od_q      <= '0;
            buf_dout_q    <= '0;
            pwm_on_q      <= PWM_ON_RST;
            pwm_off_q     <= PWM_OFF_RST;
            pwm_on_sh_q   <= PWM_ON_RST;
            pwm_off_sh_q  <= PWM_OFF_RST;
            enable_q      <= 1'b0;
            scratch_q     <= '0;
            apply_pulse_q <= 1'b0;
        end else begin
            ce_sync_q     <= ce_sync_d;
            we_sync_q     <= we_sync_d;
            oe_sync_q     <= oe_sync_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                add_sync_q[i]  <= add_sync_d[i];
                din_sync_q[i]  <= din_sync_d[i];
                bdin_sync_q[i] <= bdin_sync_d[i];
            end
            state_q       <= state_d;
            mc_dout_q     <= mc_dout_d;
            mc_dout_en_q  <= mc_dout_en_d;
            buf_oe_q      <= buf_oe_d;
            buf_dir_q     <= buf_dir_d;
            buf_od_q      <= buf_od_d;
            buf_dout_q    <= buf_dout_d;
            pwm_on_q      <= pwm_on_d;
            pwm_off_q     <= pwm_off_d;
            pwm_on_sh_q   <= pwm_on_sh_d;
            pwm_off_sh_q  <= pwm_off_sh_d;
            enable_q      <= enable_d;
            scratch_q     <= scratch_d;
            apply_pulse_q <= apply_pulse_d;
        end
    end

    assign mc_dout    = mc_dout_q;
    assign mc_dout_en = mc_dout_en_q;
    assign buf_oe     = buf_oe_q;
    assign buf_dir    = buf_dir_q;
    assign buf_od     = buf_od_q;
    assign buf_dout   = buf_dout_q;
    assign pwm_on     = pwm_on_q;
    assign pwm_off    = pwm_off_q;
    // Held low only while enabled and not in the cycle right after a period reload.
    assign pwm_reset  = ~enable_q | apply_pulse_q;

endmodule

// File: tb/tb_mc_bus_regs.sv
// Directed bench for mc_bus_regs: MCU bus reads/writes, PWM reload, abort and mid-read reset.
module tb_mc_bus_regs;

    logic        clock = 1'b0;
    logic        reset;
    logic        mc_ce, mc_we, mc_oe;
    logic [5:0]  mc_add;
    logic [15:0] mc_din;
    logic [15:0] mc_dout;
    logic        mc_dout_en;
    logic [4:0]  buf_oe, buf_dir, buf_od, buf_dout, buf_din;
    logic [15:0] pwm_on, pwm_off;
    logic        pwm_reset;

    int n_checks = 0;
    int n_pass   = 0;

    mc_bus_regs dut (
        .clock      (clock),
        .reset      (reset),
        .mc_ce      (mc_ce),
        .mc_we      (mc_we),
        .mc_oe      (mc_oe),
        .mc_add     (mc_add),
        .mc_din     (mc_din),
        .mc_dout    (mc_dout),
        .mc_dout_en (mc_dout_en),
        .buf_oe     (buf_oe),
        .buf_dir    (buf_dir),
        .buf_od     (buf_od),
        .buf_dout   (buf_dout),
        .buf_din    (buf_din),
        .pwm_on     (pwm_on),
        .pwm_off    (pwm_off),
        .pwm_reset  (pwm_reset)
    );

    always #5 clock = ~clock;

    // Advance n rising edges, then settle 1ns past the edge for driving and sampling.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr_begin(input logic [5:0] a, input logic [15:0] d);
        mc_add = a;
        mc_din = d;
        mc_ce  = 1'b0;
        mc_we  = 1'b0;
        tick(4);
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] d);
        wr_begin(a, d);
        mc_we = 1'b1;
        tick(4);
        mc_ce = 1'b1;
        tick(2);
    endtask

    task automatic rd(input logic [5:0] a, output logic [15:0] d, output logic en);
        mc_add = a;
        mc_ce  = 1'b0;
        mc_oe  = 1'b0;
        tick(3);
        d  = mc_dout;
        en = mc_dout_en;
        mc_oe = 1'b1;
        mc_ce = 1'b1;
        tick(4);
    endtask

    initial begin
        logic [15:0] rdat;
        logic        ren;

        reset = 1'b1; mc_ce = 1'b1; mc_we = 1'b1; mc_oe = 1'b1;
        mc_add = '0; mc_din = '0; buf_din = '0;
        tick(2);
        chk("rst_dout_en", {31'd0, mc_dout_en}, 32'd0);
        chk("rst_dout", {16'd0, mc_dout}, 32'd0);
        chk("rst_buf", {12'd0, buf_oe, buf_dir, buf_od, buf_dout}, 32'd0);
        chk("rst_pwm_on", {16'd0, pwm_on}, 32'h0002);
        chk("rst_pwm_off", {16'd0, pwm_off}, 32'h0081);
        chk("rst_pwm_reset", {31'd0, pwm_reset}, 32'd1);
        reset = 1'b0;
        tick(1);

        // ID read with exact latency on both edges of mc_oe
        mc_add = 6'h00; mc_ce = 1'b0; mc_oe = 1'b0;
        tick(2);
        chk("rd_lat_early", {31'd0, mc_dout_en}, 32'd0);
        tick(1);
        chk("rd_lat_en", {31'd0, mc_dout_en}, 32'd1);
        chk("rd_id", {16'd0, mc_dout}, 32'hB9A1);
        mc_oe = 1'b1;
        tick(2);
        chk("rd_drop_early", {31'd0, mc_dout_en}, 32'd1);
        tick(1);
        chk("rd_drop", {31'd0, mc_dout_en}, 32'd0);
        mc_ce = 1'b1;
        tick(2);

        // Shadow writes alone leave the applied periods untouched
        wr(6'h02, 16'h0010);
        wr(6'h03, 16'h0020);
        chk("shadow_pwm_on", {16'd0, pwm_on}, 32'h0002);
        chk("shadow_pwm_off", {16'd0, pwm_off}, 32'h0081);
        rd(6'h02, rdat, ren);
        chk("rd_shadow_on", {15'd0, ren, rdat}, {15'd0, 1'b1, 16'h0010});

        // Enable + reload: apply lands one edge after the synced WE rise, pulse lasts one clock
        wr_begin(6'h01, 16'h0003);
        mc_we = 1'b1;
        tick(2);
        chk("apply_not_yet", {16'd0, pwm_on}, 32'h0002);
        tick(1);
        chk("apply_on", {16'd0, pwm_on}, 32'h0010);
        chk("apply_off", {16'd0, pwm_off}, 32'h0020);
        chk("pwm_reset_pulse", {31'd0, pwm_reset}, 32'd1);
        tick(1);
        chk("pwm_reset_low", {31'd0, pwm_reset}, 32'd0);
        tick(2);
        mc_ce = 1'b1;
        tick(2);
        rd(6'h01, rdat, ren);
        chk("rd_ctrl", {16'd0, rdat}, 32'h0001);

        // Buffer registers mask to 5 bits
        wr(6'h04, 16'hFFFF);
        rd(6'h04, rdat, ren);
        chk("rd_buf_oe", {16'd0, rdat}, 32'h001F);
        chk("buf_oe_out", {27'd0, buf_oe}, 32'h1F);
        wr(6'h07, 16'h0015);
        chk("buf_dout_out", {27'd0, buf_dout}, 32'h15);
        chk("buf_dir_untouched", {27'd0, buf_dir}, 32'h00);

        // BUF_DIN is read-only
        buf_din = 5'b01010;
        tick(3);
        rd(6'h08, rdat, ren);
        chk("rd_buf_din", {16'd0, rdat}, 32'h000A);
        wr(6'h08, 16'hFFFF);
        rd(6'h08, rdat, ren);
        chk("rd_buf_din_ro", {16'd0, rdat}, 32'h000A);

        // Unmapped address reads 0
        wr(6'h2A, 16'h5555);
        rd(6'h2A, rdat, ren);
        chk("rd_unmapped", {15'd0, ren, rdat}, {15'd0, 1'b1, 16'h0000});

        // Abort: CE rises while WE still low, then WE rises with CE high
        mc_add = 6'h09; mc_din = 16'hBEEF; mc_ce = 1'b0; mc_we = 1'b0;
        tick(4);
        mc_ce = 1'b1;
        tick(4);
        mc_we = 1'b1;
        tick(4);
        rd(6'h09, rdat, ren);
        chk("abort_scratch", {16'd0, rdat}, 32'h0000);

        // Simultaneous CE/WE rise still commits
        mc_add = 6'h09; mc_din = 16'h1234; mc_ce = 1'b0; mc_we = 1'b0;
        tick(4);
        mc_ce = 1'b1; mc_we = 1'b1;
        tick(4);
        rd(6'h09, rdat, ren);
        chk("simul_scratch", {16'd0, rdat}, 32'h1234);

        // Reset during an active read of BUF_OE
        mc_add = 6'h04; mc_ce = 1'b0; mc_oe = 1'b0;
        tick(3);
        chk("pre_rst_en", {15'd0, mc_dout_en, mc_dout}, {15'd0, 1'b1, 16'h001F});
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("midrst_en", {31'd0, mc_dout_en}, 32'd0);
        chk("midrst_buf", {12'd0, buf_oe, buf_dir, buf_od, buf_dout}, 32'd0);
        chk("midrst_pwm", {pwm_on, pwm_off}, 32'h0002_0081);
        chk("midrst_pwm_reset", {31'd0, pwm_reset}, 32'd1);
        tick(2);
        chk("rerd_idle", {31'd0, mc_dout_en}, 32'd0);
        tick(1);
        chk("rerd_en", {15'd0, mc_dout_en, mc_dout}, {15'd0, 1'b1, 16'h0000});
        mc_oe = 1'b1; mc_ce = 1'b1;
        tick(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
